// File: rtl/vx_alu_dotp.sv
`default_nettype none
// ============================================================================
// Module   : vx_alu_dotp
// Brief    : Pipelined per-lane int8/int4 dot-product with optional
//            accumulate and saturation, valid/ready handshaked both ends.
// Revision : 1.0 - initial release
// ============================================================================
module vx_alu_dotp #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8,
    parameter int LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [1:0]                mode_in,
    input  logic                      acc_en_in,
    input  logic                      sat_en_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    input  logic [NUM_LANES*32-1:0]   rs1_data,
    input  logic [NUM_LANES*32-1:0]   rs2_data,
    input  logic [NUM_LANES*32-1:0]   rs3_data,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic [NUM_LANES*32-1:0]   result,
    output logic [31:0]               op_count
);

    localparam int c_DATA_W = NUM_LANES * 32;

    // Operands are widened to 32 bits before multiplying; the true products
    // and their sum always fit, so plain 32-bit wrapping arithmetic is exact.
    function automatic logic [31:0] lane_dotp(
        input logic [1:0]  mode,
        input logic        acc_en,
        input logic        sat_en,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c
    );
        logic [31:0] sum;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] addend;
        logic [32:0] ext;
        logic [31:0] res;
        logic        sgn;
        sgn = ~mode[0];
        sum = '0;
        if (!mode[1]) begin
            for (int k = 0; k < 4; k++) begin
                ea  = {{24{sgn & a[8*k+7]}}, a[8*k +: 8]};
                eb  = {{24{sgn & b[8*k+7]}}, b[8*k +: 8]};
                sum = sum + ea * eb;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                ea  = {{28{sgn & a[4*k+3]}}, a[4*k +: 4]};
                eb  = {{28{sgn & b[4*k+3]}}, b[4*k +: 4]};
                sum = sum + ea * eb;
            end
        end
        addend = acc_en ? c : '0;
        // 33-bit add: sign-extended in signed modes, zero-extended otherwise
        ext = {sgn & sum[31], sum} + {sgn & addend[31], addend};
        if (!sat_en) begin
            res = ext[31:0];
        end else if (sgn) begin
            if (ext[32] != ext[31])
                res = ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else
                res = ext[31:0];
        end else begin
            res = ext[32] ? 32'hFFFF_FFFF : ext[31:0];
        end
        return res;
    endfunction

    logic [c_DATA_W-1:0]  w_lane_res;
    logic                 w_stall;
    logic                 w_accept;

    logic [LATENCY-1:0]   r_valid;
    logic [TAG_WIDTH-1:0] r_tag  [LATENCY];
    logic [c_DATA_W-1:0]  r_data [LATENCY];

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign w_lane_res[l*32 +: 32] = lane_dotp(mode_in, acc_en_in, sat_en_in,
                                                      rs1_data[l*32 +: 32],
                                                      rs2_data[l*32 +: 32],
                                                      rs3_data[l*32 +: 32]);
        end
    endgenerate

    assign valid_out = r_valid[LATENCY-1];
    assign tag_out   = r_tag[LATENCY-1];
    assign result    = r_data[LATENCY-1];
    assign w_stall   = valid_out & ~ready_out;
    assign ready_in  = ~w_stall;
    assign w_accept  = valid_in & ready_in;

    // The whole pipe moves as one; a stall freezes every stage in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            op_count <= '0;
        end else begin
            if (!w_stall) begin
                r_valid[0] <= valid_in;
                for (int s = 1; s < LATENCY; s++)
                    r_valid[s] <= r_valid[s-1];
            end
            if (w_accept)
                op_count <= op_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_tag[0]  <= tag_in;
            r_data[0] <= w_lane_res;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag[s]  <= r_tag[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

endmodule
`default_nettype wire
